// File: rtl/extract_main_stream_attributes_two_channels_if.sv
// Symbol-stream input and decoded MSA outputs for the two-lane MSA extractor.
interface extract_main_stream_attributes_two_channels_if;
  logic [72:0] in_data;
  logic [23:0] M_value;
  logic [23:0] N_value;
  logic [11:0] H_visible;
  logic [11:0] V_visible;
  logic [11:0] H_total;
  logic [11:0] V_total;
  logic [11:0] H_sync_width;
  logic [11:0] V_sync_width;
  logic [11:0] H_start;
  logic [11:0] V_start;
  logic        H_vsync_active_high;
  logic        V_vsync_active_high;
  logic        flag_sync_clock;
  logic        flag_YCCnRGB;
  logic        flag_422n444;
  logic        flag_range_reduced;
  logic        flag_interlaced_even;
  logic        flag_YCC_colour_709;
  logic [1:0]  flags_3d_Indicators;
  logic [4:0]  bits_per_colour;
  logic        msa_valid;
  logic        msa_error;

  modport slave (
    input  in_data,
    output M_value, N_value, H_visible, V_visible, H_total, V_total,
           H_sync_width, V_sync_width, H_start, V_start,
           H_vsync_active_high, V_vsync_active_high, flag_sync_clock,
           flag_YCCnRGB, flag_422n444, flag_range_reduced,
           flag_interlaced_even, flag_YCC_colour_709, flags_3d_Indicators,
           bits_per_colour, msa_valid, msa_error
  );

  modport master (
    output in_data,
    input  M_value, N_value, H_visible, V_visible, H_total, V_total,
           H_sync_width, V_sync_width, H_start, V_start,
           H_vsync_active_high, V_vsync_active_high, flag_sync_clock,
           flag_YCCnRGB, flag_422n444, flag_range_reduced,
           flag_interlaced_even, flag_YCC_colour_709, flags_3d_Indicators,
           bits_per_colour, msa_valid, msa_error
  );
endinterface

// File: rtl/extract_main_stream_attributes_two_channels.sv
// Two-lane MSA extractor: detects the four-SS start pattern, captures nine
// data beats into shadow registers, checks them, and commits the decoded
// fields to the visible outputs only when the whole packet is clean.
module extract_main_stream_attributes_two_channels (
  input  logic clk,
  input  logic reset,
  extract_main_stream_attributes_two_channels_if.slave bus
);

  localparam logic [8:0] SS = 9'h15C;
  localparam logic [8:0] SE = 9'h1FD;
  localparam logic [8:0] BS = 9'h1BC;

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  typedef struct packed {
    logic [23:0] m;
    logic [23:0] n;
    logic [11:0] hvis;
    logic [11:0] vvis;
    logic [11:0] htot;
    logic [11:0] vtot;
    logic [11:0] hsw;
    logic [11:0] vsw;
    logic [11:0] hst;
    logic [11:0] vst;
    logic        hpol;
    logic        vpol;
    logic        sync_clk;
    logic        ycc;
    logic        s422;
    logic        range_red;
    logic        interlaced;
    logic        c709;
    logic [1:0]  f3d;
    logic [4:0]  bpc;
  } vis_t;

  // Control symbols (K flag, or BS explicitly) are illegal in data beats.
  function automatic logic f_is_ctrl(input logic [8:0] sym);
    return sym[8] | (sym == BS);
  endfunction

  function automatic logic [4:0] f_bpc(input logic [2:0] code);
    case (code)
      3'd0:    return 5'd6;
      3'd1:    return 5'd8;
      3'd2:    return 5'd10;
      3'd3:    return 5'd12;
      3'd4:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  state_t      r_state;
  logic [3:0]  r_k;
  logic        r_valid;
  logic        r_error;
  vis_t        r_vis;

  logic [23:0] r_m;
  logic [23:0] r_n;
  logic [11:0] r_htot, r_vtot, r_hst, r_vst, r_hsw, r_vsw, r_hvis, r_vvis;
  logic        r_hpol, r_vpol;
  logic [7:0]  r_misc0, r_misc1;

  logic [8:0]  w_l0d0, w_l0d1, w_l1d0, w_l1d1;
  logic        w_all_ss;
  logic        w_k_err, w_m_err, w_misc_err, w_se_err, w_fail;
  vis_t        w_commit;
  logic        w_unused_bits;

  assign w_l0d0   = bus.in_data[8:0];
  assign w_l0d1   = bus.in_data[17:9];
  assign w_l1d0   = bus.in_data[26:18];
  assign w_l1d1   = bus.in_data[35:27];
  assign w_all_ss = (w_l0d0 == SS) && (w_l0d1 == SS) && (w_l1d0 == SS) && (w_l1d1 == SS);
  assign w_unused_bits = ^{bus.in_data[72:36], r_misc1[7:3]};

  // Per-beat integrity checks; M copies in beats 5/6 are compared against
  // the lane-0 copy already captured in beats 1/2.
  always_comb begin
    w_k_err    = 1'b0;
    w_m_err    = 1'b0;
    w_misc_err = 1'b0;
    w_se_err   = 1'b0;
    if (r_state == S_CAPTURE) begin
      if (r_k <= 4'd9)
        w_k_err = f_is_ctrl(w_l0d0) | f_is_ctrl(w_l0d1) | f_is_ctrl(w_l1d0) | f_is_ctrl(w_l1d1);
      case (r_k)
        4'd1:    w_m_err = (w_l1d0[7:0] != w_l0d0[7:0]) || (w_l1d1[7:0] != w_l0d1[7:0]);
        4'd2:    w_m_err = (w_l1d0[7:0] != w_l0d0[7:0]);
        4'd5:    w_m_err = (w_l0d1[7:0] != r_m[23:16]) || (w_l1d1[7:0] != r_m[23:16]);
        4'd6:    w_m_err = (w_l0d0[7:0] != r_m[15:8]) || (w_l0d1[7:0] != r_m[7:0]) ||
                           (w_l1d0[7:0] != r_m[15:8]) || (w_l1d1[7:0] != r_m[7:0]);
        4'd8:    w_misc_err = (w_l1d1[2:1] == 2'b11);
        4'd10:   w_se_err = (w_l0d0 != SE) || (w_l1d0 != SE);
        default: ;
      endcase
    end
    w_fail = w_k_err | w_m_err | w_misc_err | w_se_err;
  end

  // Decoded view of the shadow registers, loaded into the outputs on commit.
  always_comb begin
    w_commit            = '0;
    w_commit.m          = r_m;
    w_commit.n          = r_n;
    w_commit.hvis       = r_hvis;
    w_commit.vvis       = r_vvis;
    w_commit.htot       = r_htot;
    w_commit.vtot       = r_vtot;
    w_commit.hsw        = r_hsw;
    w_commit.vsw        = r_vsw;
    w_commit.hst        = r_hst;
    w_commit.vst        = r_vst;
    w_commit.hpol       = r_hpol;
    w_commit.vpol       = r_vpol;
    w_commit.sync_clk   = r_misc0[0];
    w_commit.range_red  = r_misc0[3];
    w_commit.c709       = r_misc0[4];
    w_commit.bpc        = f_bpc(r_misc0[7:5]);
    w_commit.interlaced = r_misc1[0];
    w_commit.f3d        = r_misc1[2:1];
    case (r_misc0[2:1])
      2'b01:   begin w_commit.ycc = 1'b1; w_commit.s422 = 1'b1; end
      2'b10:   begin w_commit.ycc = 1'b1; w_commit.s422 = 1'b0; end
      default: begin w_commit.ycc = 1'b0; w_commit.s422 = 1'b0; end
    endcase
  end

  // Shadow capture of beat payloads; only meaningful while capturing.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) begin
      case (r_k)
        4'd1: begin
          r_m[23:16] <= w_l0d0[7:0];
          r_m[15:8]  <= w_l0d1[7:0];
        end
        4'd2: begin
          r_m[7:0]     <= w_l0d0[7:0];
          r_htot[11:8] <= w_l0d1[3:0];
          r_hst[11:8]  <= w_l1d1[3:0];
        end
        4'd3: begin
          r_htot[7:0]  <= w_l0d0[7:0];
          r_vtot[11:8] <= w_l0d1[3:0];
          r_hst[7:0]   <= w_l1d0[7:0];
          r_vst[11:8]  <= w_l1d1[3:0];
        end
        4'd4: begin
          r_vtot[7:0] <= w_l0d0[7:0];
          r_hpol      <= w_l0d1[7];
          r_hsw[11:8] <= w_l0d1[3:0];
          r_vst[7:0]  <= w_l1d0[7:0];
          r_vpol      <= w_l1d1[7];
          r_vsw[11:8] <= w_l1d1[3:0];
        end
        4'd5: begin
          r_hsw[7:0] <= w_l0d0[7:0];
          r_vsw[7:0] <= w_l1d0[7:0];
        end
        4'd7: begin
          r_hvis     <= {w_l0d0[3:0], w_l0d1[7:0]};
          r_n[23:16] <= w_l1d0[7:0];
          r_n[15:8]  <= w_l1d1[7:0];
        end
        4'd8: begin
          r_vvis   <= {w_l0d0[3:0], w_l0d1[7:0]};
          r_n[7:0] <= w_l1d0[7:0];
          r_misc0  <= w_l1d1[7:0];
        end
        4'd9: begin
          r_misc1 <= w_l1d0[7:0];
        end
        default: ;
      endcase
    end
  end

  // Capture FSM with registered pulses and committed output fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= 4'd0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_vis   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_all_ss) begin
            r_state <= S_CAPTURE;
            r_k     <= 4'd1;
          end
        end
        S_CAPTURE: begin
          if (w_all_ss) begin
            r_error <= 1'b1;
            r_k     <= 4'd1;
          end else if (w_fail) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
            r_k     <= 4'd0;
          end else if (r_k == 4'd10) begin
            r_valid <= 1'b1;
            r_vis   <= w_commit;
            r_state <= S_IDLE;
            r_k     <= 4'd0;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_k     <= 4'd0;
        end
      endcase
    end
  end

  assign bus.M_value              = r_vis.m;
  assign bus.N_value              = r_vis.n;
  assign bus.H_visible            = r_vis.hvis;
  assign bus.V_visible            = r_vis.vvis;
  assign bus.H_total              = r_vis.htot;
  assign bus.V_total              = r_vis.vtot;
  assign bus.H_sync_width         = r_vis.hsw;
  assign bus.V_sync_width         = r_vis.vsw;
  assign bus.H_start              = r_vis.hst;
  assign bus.V_start              = r_vis.vst;
  assign bus.H_vsync_active_high  = r_vis.hpol;
  assign bus.V_vsync_active_high  = r_vis.vpol;
  assign bus.flag_sync_clock      = r_vis.sync_clk;
  assign bus.flag_YCCnRGB         = r_vis.ycc;
  assign bus.flag_422n444         = r_vis.s422;
  assign bus.flag_range_reduced   = r_vis.range_red;
  assign bus.flag_interlaced_even = r_vis.interlaced;
  assign bus.flag_YCC_colour_709  = r_vis.c709;
  assign bus.flags_3d_Indicators  = r_vis.f3d;
  assign bus.bits_per_colour      = r_vis.bpc;
  assign bus.msa_valid            = r_valid;
  assign bus.msa_error            = r_error;

endmodule

// File: tb/tb_extract_main_stream_attributes_two_channels.sv
// Bench for the two-lane MSA extractor: directed vector table, hand-written
// reset / restart sequences, and randomized packets checked against a
// packet-level reference model.
module tb_extract_main_stream_attributes_two_channels;

  localparam logic [8:0] SS = 9'h15C;
  localparam logic [8:0] SE = 9'h1FD;
  localparam logic [8:0] BS = 9'h1BC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  extract_main_stream_attributes_two_channels_if bus();

  extract_main_stream_attributes_two_channels dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [23:0] m, n;
    logic [11:0] htot, hvis, vtot, vvis, hsw, vsw, hst, vst;
    logic        hpol, vpol;
    logic [7:0]  misc0, misc1;
  } msa_t;

  typedef struct packed {
    logic [23:0] m;
    logic [23:0] n;
    logic [11:0] hvis, vvis, htot, vtot, hsw, vsw, hst, vst;
    logic hpol, vpol, sync_clk, ycc, s422, range_red, interlaced, c709;
    logic [1:0] f3d;
    logic [4:0] bpc;
  } out_t;

  typedef struct {
    logic [7:0] misc0;
    int         cb;
    int         cp;
    logic [8:0] cv;
    int         exp_err;
    int         exp_val;
    logic [4:0] bpc;
    logic       ycc, s422, sync;
  } vec_t;

  logic [8:0] bt [0:10][0:3];
  out_t cur_exp;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] dsym(input logic [7:0] b);
    return {1'b0, b};
  endfunction

  task automatic build_beats(input msa_t a);
    for (int p = 0; p < 4; p++) bt[0][p] = SS;
    bt[1] = '{dsym(a.m[23:16]), dsym(a.m[15:8]), dsym(a.m[23:16]), dsym(a.m[15:8])};
    bt[2] = '{dsym(a.m[7:0]), dsym({4'($urandom), a.htot[11:8]}),
              dsym(a.m[7:0]), dsym({4'($urandom), a.hst[11:8]})};
    bt[3] = '{dsym(a.htot[7:0]), dsym({4'($urandom), a.vtot[11:8]}),
              dsym(a.hst[7:0]), dsym({4'($urandom), a.vst[11:8]})};
    bt[4] = '{dsym(a.vtot[7:0]), dsym({a.hpol, 3'($urandom), a.hsw[11:8]}),
              dsym(a.vst[7:0]), dsym({a.vpol, 3'($urandom), a.vsw[11:8]})};
    bt[5] = '{dsym(a.hsw[7:0]), dsym(a.m[23:16]), dsym(a.vsw[7:0]), dsym(a.m[23:16])};
    bt[6] = '{dsym(a.m[15:8]), dsym(a.m[7:0]), dsym(a.m[15:8]), dsym(a.m[7:0])};
    bt[7] = '{dsym({4'($urandom), a.hvis[11:8]}), dsym(a.hvis[7:0]),
              dsym(a.n[23:16]), dsym(a.n[15:8])};
    bt[8] = '{dsym({4'($urandom), a.vvis[11:8]}), dsym(a.vvis[7:0]),
              dsym(a.n[7:0]), dsym(a.misc0)};
    bt[9] = '{dsym(8'($urandom)), dsym(8'($urandom)), dsym(a.misc1), dsym(8'($urandom))};
    bt[10] = '{SE, 9'($urandom), SE, 9'($urandom)};
  endtask

  // Reference: the fields a receiver reads out of a clean packet.
  function automatic out_t model_parse();
    int bpc_tab [8] = '{6, 8, 10, 12, 16, 0, 0, 0};
    out_t o;
    logic [7:0] misc0, misc1;
    misc0 = bt[8][3][7:0];
    misc1 = bt[9][2][7:0];
    o.m    = {bt[1][0][7:0], bt[1][1][7:0], bt[2][0][7:0]};
    o.n    = {bt[7][2][7:0], bt[7][3][7:0], bt[8][2][7:0]};
    o.hvis = {bt[7][0][3:0], bt[7][1][7:0]};
    o.vvis = {bt[8][0][3:0], bt[8][1][7:0]};
    o.htot = {bt[2][1][3:0], bt[3][0][7:0]};
    o.vtot = {bt[3][1][3:0], bt[4][0][7:0]};
    o.hsw  = {bt[4][1][3:0], bt[5][0][7:0]};
    o.vsw  = {bt[4][3][3:0], bt[5][2][7:0]};
    o.hst  = {bt[2][3][3:0], bt[3][2][7:0]};
    o.vst  = {bt[3][3][3:0], bt[4][2][7:0]};
    o.hpol = bt[4][1][7];
    o.vpol = bt[4][3][7];
    o.sync_clk   = misc0[0];
    o.ycc        = (misc0[2:1] != 2'b00);
    o.s422       = (misc0[2:1] == 2'b01);
    o.range_red  = misc0[3];
    o.c709       = misc0[4];
    o.interlaced = misc1[0];
    o.f3d        = misc1[2:1];
    o.bpc        = 5'(bpc_tab[misc0[7:5]]);
    return o;
  endfunction

  // Reference: earliest beat at which the packet becomes provably bad (0 = clean).
  function automatic int model_fail();
    int cb [4][3] = '{'{1, 1, 2}, '{1, 1, 2}, '{5, 6, 6}, '{5, 6, 6}};
    int cp [4][3] = '{'{0, 1, 0}, '{2, 3, 2}, '{1, 0, 1}, '{3, 2, 3}};
    int first = 99;
    for (int b = 1; b <= 9; b++)
      for (int p = 0; p < 4; p++)
        if (bt[b][p][8] && b < first) first = b;
    for (int c = 1; c < 4; c++)
      for (int j = 0; j < 3; j++)
        if (bt[cb[c][j]][cp[c][j]][7:0] != bt[cb[0][j]][cp[0][j]][7:0]) begin
          int at = (cb[c][j] > cb[0][j]) ? cb[c][j] : cb[0][j];
          if (at < first) first = at;
        end
    if (bt[8][3][2:1] == 2'b11 && 8 < first) first = 8;
    if ((bt[10][0] != SE || bt[10][2] != SE) && 10 < first) first = 10;
    return (first == 99) ? 0 : first;
  endfunction

  function automatic out_t get_dut();
    out_t o;
    o.m = bus.M_value;           o.n = bus.N_value;
    o.hvis = bus.H_visible;      o.vvis = bus.V_visible;
    o.htot = bus.H_total;        o.vtot = bus.V_total;
    o.hsw = bus.H_sync_width;    o.vsw = bus.V_sync_width;
    o.hst = bus.H_start;         o.vst = bus.V_start;
    o.hpol = bus.H_vsync_active_high;
    o.vpol = bus.V_vsync_active_high;
    o.sync_clk = bus.flag_sync_clock;
    o.ycc = bus.flag_YCCnRGB;
    o.s422 = bus.flag_422n444;
    o.range_red = bus.flag_range_reduced;
    o.interlaced = bus.flag_interlaced_even;
    o.c709 = bus.flag_YCC_colour_709;
    o.f3d = bus.flags_3d_Indicators;
    o.bpc = bus.bits_per_colour;
    return o;
  endfunction

  // Beat e of the packet (e > 10 is idle filler); bits above the lanes are noise.
  task automatic drive(input int e);
    logic [36:0] hi;
    hi = 37'({$urandom, $urandom});
    if (e <= 10) bus.in_data = {hi, bt[e][3], bt[e][2], bt[e][1], bt[e][0]};
    else         bus.in_data = {hi, 36'h0};
  endtask

  // Edge index e is the clock edge sampling beat e (SS at e = 0).
  task automatic run_msa(output int err_e, output int val_e, output int npulse, output int both);
    err_e = -1; val_e = -1; npulse = 0; both = 0;
    for (int e = 0; e <= 13; e++) begin
      drive(e);
      @(posedge clk); #1;
      if (bus.msa_error) begin if (err_e < 0) err_e = e; npulse++; end
      if (bus.msa_valid) begin if (val_e < 0) val_e = e; npulse++; end
      if (bus.msa_error && bus.msa_valid) both++;
    end
  endtask

  task automatic check_run(input string tag, input int exp_err, input int exp_val);
    int ee, ve, np, bo;
    out_t want;
    want = (exp_val >= 0) ? model_parse() : cur_exp;
    run_msa(ee, ve, np, bo);
    chk({tag, "/err_edge"}, ee, exp_err);
    chk({tag, "/valid_edge"}, ve, exp_val);
    chk({tag, "/pulses"}, np, (exp_err >= 0 ? 1 : 0) + (exp_val >= 0 ? 1 : 0));
    chk({tag, "/both_high"}, bo, 0);
    chk({tag, "/fields"}, get_dut(), want);
    cur_exp = want;
  endtask

  msa_t base;
  vec_t tab [10];

  initial begin
    int ee, ve, np, bo, fb, kind, b, p, bit_i;
    msa_t r;

    base = '{m: 24'h012345, n: 24'h080000, htot: 12'd2200, hvis: 12'd1920,
             vtot: 12'd1125, vvis: 12'd1080, hsw: 12'd44, vsw: 12'd5,
             hst: 12'd192, vst: 12'd41, hpol: 1'b1, vpol: 1'b1,
             misc0: 8'h21, misc1: 8'h00};

    //           misc0  cb cp  cv      err val bpc   ycc  422  sync
    tab[0] = '{8'h21, 0, 0, 9'h000, -1, 10, 5'd8,  1'b0, 1'b0, 1'b1};
    tab[1] = '{8'h21, 6, 2, 9'h024,  6, -1, 5'd0,  1'b0, 1'b0, 1'b0};
    tab[2] = '{8'h21, 10, 0, 9'h000, 10, -1, 5'd0, 1'b0, 1'b0, 1'b0};
    tab[3] = '{8'h06, 0, 0, 9'h000,  8, -1, 5'd0,  1'b0, 1'b0, 1'b0};
    tab[4] = '{8'h82, 0, 0, 9'h000, -1, 10, 5'd16, 1'b1, 1'b1, 1'b0};
    tab[5] = '{8'h21, 3, 3, BS,      3, -1, 5'd0,  1'b0, 1'b0, 1'b0};
    tab[6] = '{8'h44, 0, 0, 9'h000, -1, 10, 5'd10, 1'b1, 1'b0, 1'b0};
    tab[7] = '{8'hE0, 0, 0, 9'h000, -1, 10, 5'd0,  1'b0, 1'b0, 1'b0};
    tab[8] = '{8'h21, 10, 1, 9'h000, -1, 10, 5'd8, 1'b0, 1'b0, 1'b1};
    tab[9] = '{8'h21, 1, 3, 9'h024,  1, -1, 5'd0,  1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    bus.in_data = '0;
    repeat (3) begin
      @(posedge clk); #1;
      bus.in_data = {37'h0, SS, SS, SS, SS};
    end
    chk("reset/fields", get_dut(), '0);
    chk("reset/pulses", {bus.msa_valid, bus.msa_error}, 2'b00);
    reset = 1'b0;
    cur_exp = '0;

    // Directed vectors; the first starts in the very first post-reset cycle.
    for (int i = 0; i < 10; i++) begin
      base.misc0 = tab[i].misc0;
      build_beats(base);
      if (tab[i].cb != 0) bt[tab[i].cb][tab[i].cp] = tab[i].cv;
      check_run($sformatf("vec%0d", i), tab[i].exp_err, tab[i].exp_val);
      if (tab[i].exp_val >= 0) begin
        chk($sformatf("vec%0d/bpc", i), bus.bits_per_colour, tab[i].bpc);
        chk($sformatf("vec%0d/ycc_422_sync", i),
            {bus.flag_YCCnRGB, bus.flag_422n444, bus.flag_sync_clock},
            {tab[i].ycc, tab[i].s422, tab[i].sync});
        chk($sformatf("vec%0d/m_n", i), {bus.M_value, bus.N_value}, {24'h012345, 24'h080000});
        chk($sformatf("vec%0d/timing", i),
            {bus.H_total, bus.H_visible, bus.V_total, bus.V_visible},
            {12'd2200, 12'd1920, 12'd1125, 12'd1080});
      end
    end
    base.misc0 = 8'h21;

    // Reset during beat 5: everything cleared, no pulse, then a clean packet.
    build_beats(base);
    np = 0;
    for (int e = 0; e <= 5; e++) begin
      drive(e);
      if (e == 5) reset = 1'b1;
      @(posedge clk); #1;
      np += int'(bus.msa_valid) + int'(bus.msa_error);
    end
    chk("midreset/fields", get_dut(), '0);
    chk("midreset/pulses", np, 0);
    reset = 1'b0;
    cur_exp = '0;
    check_run("after_reset", -1, 10);

    // SS reissued at beat 4: error on that edge, restarted packet commits.
    base.m = 24'hABCDEF;
    build_beats(base);
    np = 0;
    for (int e = 0; e <= 3; e++) begin
      drive(e);
      @(posedge clk); #1;
      np += int'(bus.msa_valid) + int'(bus.msa_error);
    end
    chk("reissue/early_pulses", np, 0);
    check_run("reissue", 0, 10);
    chk("reissue/m", bus.M_value, 24'hABCDEF);

    // Randomized packets with optional single corruptions.
    for (int it = 0; it < 60; it++) begin
      r = '{m: 24'($urandom), n: 24'($urandom), htot: 12'($urandom), hvis: 12'($urandom),
            vtot: 12'($urandom), vvis: 12'($urandom), hsw: 12'($urandom), vsw: 12'($urandom),
            hst: 12'($urandom), vst: 12'($urandom), hpol: 1'($urandom), vpol: 1'($urandom),
            misc0: 8'($urandom), misc1: 8'($urandom)};
      build_beats(r);
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        b = $urandom_range(1, 10); p = $urandom_range(0, 3); bit_i = $urandom_range(0, 8);
        bt[b][p][bit_i] = ~bt[b][p][bit_i];
      end else if (kind == 2) begin
        b = $urandom_range(1, 9); p = $urandom_range(0, 3);
        bt[b][p][8] = 1'b1;
      end else if (kind == 3) begin
        bt[10][2] = 9'($urandom);
      end
      fb = model_fail();
      check_run($sformatf("rnd%0d", it), fb != 0 ? fb : -1, fb != 0 ? -1 : 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
